// File: rtl/wb_ram_slave_if.sv
// Wishbone classic bus bundle between an SoC master and the on-chip RAM responder.
// The master modport drives the request; the slave modport returns the completion.
interface wb_ram_slave_if;
  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_we;
  logic [3:0]  wb_sel;
  logic [31:0] wb_addr;
  logic [31:0] wb_wdata;
  logic        wb_ack;
  logic        wb_err;
  logic [31:0] wb_rdata;

  modport master (
    output wb_cyc, wb_stb, wb_we, wb_sel, wb_addr, wb_wdata,
    input  wb_ack, wb_err, wb_rdata
  );

  modport slave (
    input  wb_cyc, wb_stb, wb_we, wb_sel, wb_addr, wb_wdata,
    output wb_ack, wb_err, wb_rdata
  );
endinterface

// File: rtl/wb_ram_slave.sv
// Wishbone classic responder in front of a single-port word RAM: window decode,
// byte-lane writes, programmable wait states and wb_err for bad addresses.
module wb_ram_slave #(
  parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic          clk_in,
  input  logic          reset_in,
  wb_ram_slave_if.slave wb
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN  = 32'(DEPTH_WORDS * 4);
  localparam logic [3:0]  WS    = 4'(WAIT_STATES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [3:0]        r_cnt;
  logic              r_we;
  logic              r_bad;
  logic [3:0]        r_sel;
  logic [31:0]       r_wdata;
  logic [IDX_W-1:0]  r_index;
  logic [31:0]       r_rdata;
  logic [31:0]       r_mem [DEPTH_WORDS];

  logic [31:0]       w_offset;
  logic              w_req;
  logic              w_hit;
  logic              w_bad;
  logic [IDX_W-1:0]  w_index;
  logic              w_take;
  logic              w_enter_resp;
  logic              w_acc_we;
  logic              w_acc_bad;
  logic [3:0]        w_acc_sel;
  logic [31:0]       w_acc_wdata;
  logic [IDX_W-1:0]  w_acc_index;
  logic              w_ack;
  logic              w_err;

  // Unsigned wrap makes addresses below BASE_ADDR land far outside the window.
  assign w_offset = wb.wb_addr - BASE_ADDR;
  assign w_hit    = w_offset < SPAN;
  assign w_bad    = ~w_hit | (wb.wb_addr[1:0] != 2'b00);
  assign w_index  = w_offset[IDX_W+1:2];
  assign w_req    = wb.wb_cyc & wb.wb_stb;
  assign w_take   = (r_state == S_IDLE) & w_req;

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_bad   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_take) begin
        r_cnt <= WS;
        r_we  <= wb.wb_we;
        r_bad <= w_bad;
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (w_take) begin
      r_sel   <= wb.wb_sel;
      r_wdata <= wb.wb_wdata;
      r_index <= w_index;
    end
  end

  // NOTE: every variable assigned in always_comb gets a default first, so no path infers a latch.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_req) w_state_next = (w_bad || (WS == 4'd0)) ? S_RESP : S_WAIT;
      S_WAIT: begin
        if (!w_req)              w_state_next = S_IDLE;
        else if (r_cnt == 4'd1)  w_state_next = S_RESP;
      end
      S_RESP: w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // A zero-wait or bad access enters RESP straight from IDLE, before the latches hold it.
  assign w_enter_resp = (w_state_next == S_RESP);
  assign w_acc_we     = (r_state == S_IDLE) ? wb.wb_we    : r_we;
  assign w_acc_bad    = (r_state == S_IDLE) ? w_bad       : r_bad;
  assign w_acc_sel    = (r_state == S_IDLE) ? wb.wb_sel   : r_sel;
  assign w_acc_wdata  = (r_state == S_IDLE) ? wb.wb_wdata : r_wdata;
  assign w_acc_index  = (r_state == S_IDLE) ? w_index     : r_index;

  // NOTE: the RAM has no reset; only its write enable is qualified so an access in flight is dropped.
  always_ff @(posedge clk_in) begin
    if (w_enter_resp && !w_acc_bad && w_acc_we && !reset_in) begin
      for (int i = 0; i < 4; i++) begin
        if (w_acc_sel[i]) r_mem[w_acc_index][8*i +: 8] <= w_acc_wdata[8*i +: 8];
      end
    end
  end

  // NOTE: non-blocking assignment means this read sees the RAM word as it was before the edge.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      r_rdata <= 32'd0;
    end else if (w_enter_resp && !w_acc_bad && !w_acc_we) begin
      r_rdata <= r_mem[w_acc_index];
    end
  end

  always_comb begin
    w_ack = 1'b0;
    w_err = 1'b0;
    if (r_state == S_RESP) begin
      w_ack = ~r_bad;
      w_err = r_bad;
    end
  end

  assign wb.wb_ack   = w_ack;
  assign wb.wb_err   = w_err;
  assign wb.wb_rdata = r_rdata;

endmodule

// File: tb/tb_wb_ram_slave.sv
// Scoreboard bench for wb_ram_slave: three instances with 1, 3 and 0 wait states,
// expected completions queued at issue time and compared as the DUTs respond.
module tb_wb_ram_slave;

  localparam logic [31:0] BASE  = 32'h0001_0000;
  localparam int          DEPTH = 1024;
  localparam logic [31:0] SPAN  = 32'(DEPTH * 4);

  typedef struct {
    int          k;
    logic        err;
    logic [31:0] rdata;
    int          due;
  } exp_t;

  logic        clk_in = 1'b0;
  logic [2:0]  rst;
  logic [2:0]  drv_cyc, drv_stb, drv_we;
  logic [3:0]  drv_sel   [3];
  logic [31:0] drv_addr  [3];
  logic [31:0] drv_wdata [3];
  logic [2:0]  mon_ack, mon_err;
  logic [31:0] mon_rdata [3];

  logic [31:0] mdl     [3][DEPTH];
  logic [31:0] last_rd [3];
  exp_t        sb_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc_cnt = 0;

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc_cnt <= cyc_cnt + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int WS = (g == 0) ? 1 : (g == 1) ? 3 : 0;
    wb_ram_slave_if u_if ();
    assign u_if.wb_cyc   = drv_cyc[g];
    assign u_if.wb_stb   = drv_stb[g];
    assign u_if.wb_we    = drv_we[g];
    assign u_if.wb_sel   = drv_sel[g];
    assign u_if.wb_addr  = drv_addr[g];
    assign u_if.wb_wdata = drv_wdata[g];
    assign mon_ack[g]    = u_if.wb_ack;
    assign mon_err[g]    = u_if.wb_err;
    assign mon_rdata[g]  = u_if.wb_rdata;
    wb_ram_slave #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) u_dut (
      .clk_in  (clk_in),
      .reset_in(rst[g]),
      .wb      (u_if.slave)
    );
  end

  function automatic int ws_of(input int k);
    return (k == 0) ? 1 : (k == 1) ? 3 : 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk_in) begin
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      if (mon_ack[k] && mon_err[k]) check("ack_and_err", {mon_ack[k], mon_err[k]}, 32'd0);
      if (mon_ack[k] || mon_err[k]) begin
        if (sb_q.size() == 0) begin
          check("spurious_resp", {mon_ack[k], mon_err[k]}, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("resp_dut",     32'(k),       32'(e.k));
          check("resp_err",     mon_err[k],   e.err);
          check("resp_ack",     mon_ack[k],   !e.err);
          check("resp_rdata",   mon_rdata[k], e.rdata);
          check("resp_latency", cyc_cnt,      e.due);
        end
      end
    end
  end

  // Drive one request at the current negedge; optionally queue its expected completion.
  task automatic issue(input int k, input logic we, input logic [31:0] addr, input logic [3:0] sel,
                       input logic [31:0] wdata, input bit push, input int extra);
    logic [31:0] off;
    logic        bad;
    int          idx;
    exp_t        e;
    drv_cyc[k] = 1'b1; drv_stb[k] = 1'b1; drv_we[k] = we;
    drv_sel[k] = sel;  drv_addr[k] = addr; drv_wdata[k] = wdata;
    off = addr - BASE;
    bad = (off >= SPAN) || (addr[1:0] != 2'b00);
    idx = bad ? 0 : int'(off >> 2);
    if (push) begin
      e.k   = k;
      e.err = bad;
      e.due = cyc_cnt + 1 + extra + (bad ? 0 : ws_of(k));
      if (!bad && !we) last_rd[k] = mdl[k][idx];
      if (!bad && we) begin
        for (int b = 0; b < 4; b++) if (sel[b]) mdl[k][idx][8*b +: 8] = wdata[8*b +: 8];
      end
      e.rdata = last_rd[k];
      sb_q.push_back(e);
    end
  endtask

  task automatic wait_resp(input int k);
    int n;
    n = 0;
    do begin
      @(negedge clk_in);
      n++;
    end while (!(mon_ack[k] || mon_err[k]) && n < 40);
    if (!(mon_ack[k] || mon_err[k])) check("resp_timeout_cycles", 32'(n), 32'd0);
  endtask

  task automatic idle(input int k);
    drv_cyc[k] = 1'b0;
    drv_stb[k] = 1'b0;
  endtask

  task automatic single(input int k, input logic we, input logic [31:0] addr,
                        input logic [3:0] sel, input logic [31:0] wdata);
    @(negedge clk_in);
    issue(k, we, addr, sel, wdata, 1'b1, 0);
    wait_resp(k);
    idle(k);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 3'b111;
    drv_cyc = '0; drv_stb = '0; drv_we = '0;
    for (int k = 0; k < 3; k++) begin
      drv_sel[k] = '0; drv_addr[k] = '0; drv_wdata[k] = '0; last_rd[k] = '0;
    end
    #1;
    for (int k = 0; k < 3; k++) begin
      check("reset_ack",   mon_ack[k],   32'd0);
      check("reset_err",   mon_err[k],   32'd0);
      check("reset_rdata", mon_rdata[k], 32'd0);
    end
    repeat (3) @(negedge clk_in);
    rst = 3'b000;

    // One wait state: plain write/read, partial-lane writes, last word of the window.
    single(0, 1'b1, BASE + 8, 4'hF, 32'hDEAD_BEEF);
    single(0, 1'b0, BASE + 8, 4'hF, 32'h0);
    check("t1_rdata", mon_rdata[0], 32'hDEAD_BEEF);
    single(0, 1'b1, BASE + 12, 4'hF,    32'h1122_3344);
    single(0, 1'b1, BASE + 12, 4'b0101, 32'hAABB_CCDD);
    single(0, 1'b0, BASE + 12, 4'hF,    32'h0);
    check("t2_rdata", mon_rdata[0], 32'h11BB_33DD);
    single(0, 1'b1, BASE + 12, 4'b0000, 32'hFFFF_FFFF);
    single(0, 1'b0, BASE + 12, 4'h0,    32'h0);
    check("t2_sel0_rdata", mon_rdata[0], 32'h11BB_33DD);
    single(0, 1'b1, BASE + SPAN - 4, 4'hF, 32'hCAFE_F00D);
    single(0, 1'b0, BASE + SPAN - 4, 4'hF, 32'h0);

    // Out-of-window and misaligned accesses must not touch RAM or wb_rdata.
    single(0, 1'b1, BASE,            4'hF, 32'h5A5A_5A5A);
    single(0, 1'b1, BASE + SPAN,     4'hF, 32'h0BAD_0BAD);
    single(0, 1'b0, BASE - 4,        4'hF, 32'h0);
    single(0, 1'b1, BASE + 2,        4'hF, 32'h0000_0000);
    single(0, 1'b0, BASE + SPAN + 8, 4'hF, 32'h0);
    single(0, 1'b0, BASE,            4'hF, 32'h0);
    check("t3_word0", mon_rdata[0], 32'h5A5A_5A5A);

    // Three wait states: strobe dropped one cycle after the request aborts the write.
    single(1, 1'b1, BASE + 16, 4'hF, 32'h0123_4567);
    @(negedge clk_in);
    issue(1, 1'b1, BASE + 16, 4'hF, 32'hFFFF_0000, 1'b0, 0);
    @(negedge clk_in);
    drv_stb[1] = 1'b0;
    @(negedge clk_in);
    idle(1);
    repeat (8) @(negedge clk_in);
    single(1, 1'b0, BASE + 16, 4'hF, 32'h0);
    check("t4_kept", mon_rdata[1], 32'h0123_4567);

    // Asynchronous reset in the middle of the wait period.
    @(negedge clk_in);
    issue(1, 1'b1, BASE + 16, 4'hF, 32'hDEAD_DEAD, 1'b0, 0);
    @(posedge clk_in);
    @(posedge clk_in);
    #2;
    rst[1] = 1'b1;
    #1;
    check("t5_ack",   mon_ack[1],   32'd0);
    check("t5_err",   mon_err[1],   32'd0);
    check("t5_rdata", mon_rdata[1], 32'd0);
    idle(1);
    repeat (2) @(negedge clk_in);
    rst[1] = 1'b0;
    last_rd[1] = 32'd0;
    repeat (8) @(negedge clk_in);
    single(1, 1'b0, BASE + 16, 4'hF, 32'h0);
    check("t5_ram_kept", mon_rdata[1], 32'h0123_4567);

    // Zero wait states: preload eight words, then read them back to back.
    for (int i = 0; i < 8; i++)
      single(2, 1'b1, BASE + 32'(400 * i), 4'hF, 32'hC0DE_0000 ^ (32'h0101_0101 * 32'(i + 1)));
    @(negedge clk_in);
    for (int i = 0; i < 8; i++) begin
      issue(2, 1'b0, BASE + 32'(400 * i), 4'hF, 32'h0, 1'b1, (i == 0) ? 0 : 1);
      wait_resp(2);
    end
    idle(2);

    repeat (6) @(negedge clk_in);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
